// File: rtl/dmem_responder_if.sv
// Request/response bundle between the MEM-stage requester and the data-memory responder.
// The master modport is the pipeline side; the slave modport is the responder side.

interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, LATENCY wait states, then a one-cycle
// response carrying aligned/extended load data, a store ack, or a misalignment error.

module dmem_responder #(
    parameter int unsigned AW      = 10,
    parameter int unsigned LATENCY = 2
) (
    input logic             clk_i,
    input logic             rst_ni,
    dmem_responder_if.slave bus
);

    localparam int unsigned Depth   = 2 ** AW;
    localparam bit          NoWait  = (LATENCY == 0);
    localparam logic [3:0]  CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e         state_q;
    logic [3:0]     cnt_q;
    logic [AW-1:0]  idx_q;
    logic [1:0]     lane_q;
    logic [1:0]     size_q;
    logic           we_q;
    logic           signed_q;
    logic [31:0]    wdata_q;
    logic           err_q;
    logic [31:0]    rdata_q;
    logic           rsp_valid_q;
    logic [31:0]    rsp_rdata_q;
    logic           rsp_err_q;

    logic [31:0]    mem_q [Depth];

    logic           req_err;
    logic           acc_from_req;
    logic           acc_en;
    logic           acc_we;
    logic [AW-1:0]  acc_idx;
    logic [1:0]     acc_lane;
    logic [1:0]     acc_size;
    logic [31:0]    acc_wdata;
    logic [3:0]     acc_be;
    logic [31:0]    acc_wword;
    logic [31:0]    mem_rd;
    logic [7:0]     byte_v;
    logic [15:0]    half_v;
    logic [31:0]    load_data;

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

    always_comb begin
        req_err = 1'b0;
        unique case (bus.req_size)
            2'b00:   req_err = 1'b0;
            2'b01:   req_err = bus.req_addr[0];
            2'b10:   req_err = |bus.req_addr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // With no wait states the array is accessed on the accept edge straight from the request;
    // otherwise on the last wait edge from the latched copy.
    assign acc_from_req = NoWait && (state_q == StIdle) && bus.req_valid && !req_err;
    assign acc_en       = acc_from_req || ((state_q == StWait) && (cnt_q == 4'd0));

    always_comb begin
        if (acc_from_req) begin
            acc_we    = bus.req_we;
            acc_idx   = bus.req_addr[AW+1:2];
            acc_lane  = bus.req_addr[1:0];
            acc_size  = bus.req_size;
            acc_wdata = bus.req_wdata;
        end else begin
            acc_we    = we_q;
            acc_idx   = idx_q;
            acc_lane  = lane_q;
            acc_size  = size_q;
            acc_wdata = wdata_q;
        end
    end

    always_comb begin
        acc_be    = 4'hf;
        acc_wword = acc_wdata;
        unique case (acc_size)
            2'b00: begin
                acc_be    = 4'b0001 << acc_lane;
                acc_wword = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                acc_be    = acc_lane[1] ? 4'b1100 : 4'b0011;
                acc_wword = {2{acc_wdata[15:0]}};
            end
            default: begin
                acc_be    = 4'hf;
                acc_wword = acc_wdata;
            end
        endcase
    end

    assign mem_rd = mem_q[acc_idx];

    // Array contents survive reset.
    always_ff @(posedge clk_i) begin
        if (acc_en && acc_we) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem_q[acc_idx][b*8 +: 8] <= acc_wword[b*8 +: 8];
                end
            end
        end
    end

    always_comb begin
        byte_v    = rdata_q[{lane_q, 3'b000} +: 8];
        half_v    = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        load_data = rdata_q;
        unique case (size_q)
            2'b00:   load_data = {{24{signed_q & byte_v[7]}}, byte_v};
            2'b01:   load_data = {{16{signed_q & half_v[15]}}, half_v};
            default: load_data = rdata_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            we_q        <= 1'b0;
            signed_q    <= 1'b0;
            wdata_q     <= 32'd0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= (state_q == StResp);
            rsp_err_q   <= (state_q == StResp) && err_q;
            rsp_rdata_q <= ((state_q == StResp) && !err_q && !we_q) ? load_data : 32'd0;

            if (acc_en && !acc_we) begin
                rdata_q <= mem_rd;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        err_q    <= req_err;
                        idx_q    <= bus.req_addr[AW+1:2];
                        lane_q   <= bus.req_addr[1:0];
                        size_q   <= bus.req_size;
                        we_q     <= bus.req_we;
                        signed_q <= bus.req_signed;
                        wdata_q  <= bus.req_wdata;
                        if (req_err || NoWait) begin
                            state_q <= StResp;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= CntInit;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage load/store port.
- Accepts one request at a time through a valid/ready handshake. Holds the data-memory array internally.
- Inserts a programmable number of wait states, then returns a one-cycle response: load data aligned and sign/zero-extended, or a store acknowledge.
- Flags misaligned accesses so the hazard unit can hold the pipeline (`~req_ready` or a pending response) and trap later.

Parameters:
- AW, 10, word-address width; array depth is 2^AW 32-bit words.
- LATENCY, 2, wait-state cycles between acceptance and response (0..15).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present; requester holds all req_* stable until accepted.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as error).
- req_signed  input  1  loads only: 1 = sign-extend (lb/lh), 0 = zero-extend (lbu/lhu).
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result; 0 for stores and errors.
- rsp_err  output  1  valid with rsp_valid; 1 = misaligned or reserved size, no memory effect.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE, wait counter = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0; latched request cleared.
  - Array contents are not reset.
  - Reset during WAIT drops the pending request; a pending store is never written.
- FSM states IDLE, WAIT, RESP:
  - IDLE, req_valid = 1, error detected: latch err = 1, go to RESP (error bypasses wait states).
  - IDLE, req_valid = 1, no error: latch addr/size/we/signed/wdata. Go to WAIT with counter = LATENCY-1, or straight to RESP when LATENCY = 0.
  - WAIT: decrement counter. At counter = 0, go to RESP. On that same edge, perform the array write (store) or register the read data (load).
  - RESP: rsp_valid = 1 for exactly this cycle; next state IDLE.
- Latency: request accepted on edge t → rsp_valid high in the cycle after edge t+LATENCY+1. Error responses: rsp_valid in the cycle after edge t+1. Minimum spacing between accepts is LATENCY+2 cycles.
- Requests are ignored while req_ready = 0; requester must not change req_* before acceptance.
- Error detection:
  - half with addr[0] = 1 → error.
  - word with addr[1:0] != 00 → error.
  - size 11 → error.
  - On error: rsp_err = 1, rsp_rdata = 0, array unchanged.
- Addressing:
  - word index = addr[AW+1:2]; bits above AW+1 are ignored, so addresses alias/wrap modulo 2^(AW+2).
  - Little-endian lanes: byte lane = addr[1:0], half lane = addr[1].
- Stores:
  - byte writes only lane addr[1:0] with wdata[7:0].
  - half writes lanes {addr[1],1} and {addr[1],0} with wdata[15:0].
  - word writes all 32 bits.
  - Other lanes are preserved (per-byte write enables).
- Loads: extract the selected byte/half/word, right-justify, then extend per req_signed. Word loads ignore req_signed.
- Store responses: rsp_valid = 1, rsp_err = 0, rsp_rdata = 0.
- Outputs are registered; no combinational path from req_* to rsp_*. req_ready is decoded from state only.

Test Plan:
- Reset then word store 0xDEADBEEF @0x10, then word load @0x10, LATENCY = 2 → store ack 3 cycles after accept with rsp_rdata = 0; load returns 0xDEADBEEF 3 cycles after accept; req_ready low for exactly 3 cycles per request.
- Byte store 0x80 @0x21 over word 0x11223344 @0x20 → word reads 0x11228044. lb @0x21 → 0xFFFFFF80. lbu @0x21 → 0x00000080.
- Half store 0xABCD @0x22, then lh @0x22 → 0xFFFFABCD; lhu → 0x0000ABCD; lower half of word @0x20 unchanged.
- Misaligned cases:
  - lw @0x13 → rsp_err = 1, rsp_rdata = 0, 1-cycle turnaround.
  - sh @0x31 → rsp_err = 1, and a later read of @0x30 is unchanged.
  - size 11 → rsp_err = 1.
- Aliasing, AW = 10: word store 0x12345678 @0x0000_1004, load @0x0000_0004 → 0x12345678.
- Drive rst low during WAIT of a store 0xFFFFFFFF @0x40 → after release, state IDLE, rsp_valid never pulses, load @0x40 returns the prior value. Also repeat with LATENCY = 0 to confirm 1-cycle response.
